wb_daq_dma_engine: RTL and testbench

WB_DAQ_DMA_ENGINE -- requirements
Module: wb_daq_dma_engine

---
 rtl/wb_daq_pkg.sv | 26 ++
 rtl/wb_daq_rr_arbiter.sv | 41 ++++
 rtl/wb_daq_dma_engine.sv | 173 +++++++++++++++++
 tb/tb_wb_daq_dma_engine.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_daq_pkg.sv
// Shared types and Wishbone constants for the DAQ DMA engine.
package wb_daq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    function automatic int unsigned beat_count(
        input int unsigned bl,
        input int unsigned lvl,
        input int unsigned rem
    );
        int unsigned m;
        m = bl;
        if (lvl < m) m = lvl;
        if (rem < m) m = rem;
        return m;
    endfunction

endpackage

// File: rtl/wb_daq_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted channel.
module wb_daq_rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         req,
    input  logic                      advance,
    output logic [NUM_CH-1:0]         grant,
    output logic [$clog2(NUM_CH)-1:0] grant_idx
);
    localparam int IW = $clog2(NUM_CH);

    logic [IW-1:0] last_q;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = IW'((int'(last_q) + k) % NUM_CH);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IW'(NUM_CH - 1);
        end else if (advance && found) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/wb_daq_dma_engine.sv
// Multi-channel DAQ DMA: drains per-channel FIFOs into memory rings
// with Wishbone incrementing write bursts.
module wb_daq_dma_engine
    import wb_daq_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int BURST_LEN = 4,
    parameter int LEN_W     = 16
) (
    input  logic                    wb_clk,
    input  logic                    wb_rst,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH*AW-1:0]    ch_base,
    input  logic [NUM_CH*LEN_W-1:0] ch_len,
    input  logic [NUM_CH*LEN_W-1:0] ch_level,
    input  logic [NUM_CH-1:0]       ch_flush,
    input  logic [NUM_CH*DW-1:0]    ch_data,
    output logic [NUM_CH-1:0]       ch_pop,
    input  logic [NUM_CH-1:0]       err_clr,
    output logic [NUM_CH-1:0]       ch_err,
    output logic [NUM_CH-1:0]       ch_wrap,
    output logic [NUM_CH*LEN_W-1:0] ch_wr_ptr,
    output logic [AW-1:0]           wb_adr_o,
    output logic [DW-1:0]           wb_dat_o,
    output logic [3:0]              wb_sel_o,
    output logic                    wb_we_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic [2:0]              wb_cti_o,
    output logic [1:0]              wb_bte_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_rty_i
);
    localparam int IW = $clog2(NUM_CH);
    localparam logic [LEN_W-1:0] BL = LEN_W'(BURST_LEN);

    logic [AW-1:0]    base_a  [NUM_CH];
    logic [LEN_W-1:0] len_a   [NUM_CH];
    logic [LEN_W-1:0] level_a [NUM_CH];
    logic [DW-1:0]    data_a  [NUM_CH];
    logic [LEN_W-1:0] ptr_q   [NUM_CH];

    state_e            state_q;
    logic [IW-1:0]     cur_q;
    logic [4:0]        beats_q;
    logic [NUM_CH-1:0] err_q;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic [IW-1:0]     gnt_idx;
    logic [LEN_W-1:0]  rem_g;

    logic in_burst;
    logic last_beat;
    logic ack_ok;
    logic err_hit;
    logic rty_hit;
    logic wrap_now;
    logic advance;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign base_a[i]  = ch_base[i*AW +: AW];
        assign len_a[i]   = ch_len[i*LEN_W +: LEN_W];
        assign level_a[i] = ch_level[i*LEN_W +: LEN_W];
        assign data_a[i]  = ch_data[i*DW +: DW];
        assign ch_wr_ptr[i*LEN_W +: LEN_W] = ptr_q[i];

        assign req[i] = ch_enable[i] && !err_q[i] && (len_a[i] != '0) &&
                        ((level_a[i] >= BL) ||
                         (ch_flush[i] && (level_a[i] != '0)));

        assign ch_pop[i]  = ack_ok && (cur_q == IW'(i));
        assign ch_wrap[i] = wrap_now && (cur_q == IW'(i));
    end

    wb_daq_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk       (wb_clk),
        .rst_n     (wb_rst),
        .req       (req),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (gnt_idx)
    );

    assign in_burst  = (state_q == ST_BURST);
    assign last_beat = (beats_q == 5'd1);
    assign advance   = (state_q == ST_IDLE) && (|grant);

    // err wins over ack; rty only counts when neither is present
    assign err_hit = in_burst && wb_err_i;
    assign ack_ok  = in_burst && wb_ack_i && !wb_err_i;
    assign rty_hit = in_burst && wb_rty_i && !wb_err_i && !wb_ack_i;

    assign wrap_now = ack_ok && (ptr_q[cur_q] >= len_a[cur_q] - LEN_W'(1));

    // a ring shrunk below the pointer still moves one word before wrapping
    assign rem_g = (ptr_q[gnt_idx] < len_a[gnt_idx]) ?
                   (len_a[gnt_idx] - ptr_q[gnt_idx]) : LEN_W'(1);

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            beats_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (advance) begin
                        state_q <= ST_BURST;
                        cur_q   <= gnt_idx;
                        beats_q <= 5'(beat_count(BURST_LEN,
                                                 32'(level_a[gnt_idx]),
                                                 32'(rem_g)));
                    end
                end
                ST_BURST: begin
                    if (err_hit || rty_hit || (ack_ok && last_beat)) begin
                        state_q <= ST_IDLE;
                    end else if (ack_ok) begin
                        beats_q <= beats_q - 5'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            for (int i = 0; i < NUM_CH; i++) ptr_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_pop[i]) begin
                    ptr_q[i] <= ch_wrap[i] ? '0 : ptr_q[i] + LEN_W'(1);
                end else if (!ch_enable[i] &&
                             !(in_burst && cur_q == IW'(i))) begin
                    ptr_q[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            err_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (err_hit && cur_q == IW'(i)) begin
                    err_q[i] <= 1'b1;
                end else if (err_clr[i]) begin
                    err_q[i] <= 1'b0;
                end
            end
        end
    end

    assign ch_err   = err_q;
    assign wb_cyc_o = in_burst;
    assign wb_stb_o = in_burst;
    assign wb_we_o  = in_burst;
    assign wb_sel_o = in_burst ? 4'hF : 4'h0;
    assign wb_bte_o = BTE_LINEAR;
    assign wb_cti_o = !in_burst ? CTI_CLASSIC :
                      (last_beat ? CTI_EOB : CTI_INCR);
    assign wb_adr_o = in_burst ?
                      (base_a[cur_q] + (AW'(ptr_q[cur_q]) << 2)) : '0;
    assign wb_dat_o = in_burst ? data_a[cur_q] : '0;

endmodule

// File: tb/tb_wb_daq_dma_engine.sv
// Bench for wb_daq_dma_engine: FIFO/bus-slave model plus a
// transaction-level reference of arbitration and ring pointers.
module tb_wb_daq_dma_engine;
    localparam int NC = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int BL = 4;
    localparam int LW = 16;

    logic wb_clk = 1'b0;
    logic wb_rst;
    logic [NC-1:0]    ch_enable, ch_flush, ch_pop, err_clr, ch_err, ch_wrap;
    logic [NC*AW-1:0] ch_base;
    logic [NC*LW-1:0] ch_len, ch_level, ch_wr_ptr;
    logic [NC*DW-1:0] ch_data;
    logic [AW-1:0]    wb_adr_o;
    logic [DW-1:0]    wb_dat_o;
    logic [3:0]       wb_sel_o;
    logic             wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]       wb_cti_o;
    logic [1:0]       wb_bte_o;
    logic             wb_ack_i, wb_err_i, wb_rty_i;

    always #5 wb_clk = ~wb_clk;

    wb_daq_dma_engine #(
        .NUM_CH(NC), .DW(DW), .AW(AW), .BURST_LEN(BL), .LEN_W(LW)
    ) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .ch_enable(ch_enable), .ch_base(ch_base), .ch_len(ch_len),
        .ch_level(ch_level), .ch_flush(ch_flush), .ch_data(ch_data),
        .ch_pop(ch_pop), .err_clr(err_clr), .ch_err(ch_err),
        .ch_wrap(ch_wrap), .ch_wr_ptr(ch_wr_ptr),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Bench-side channel configuration and FIFO contents
    logic [31:0] base [NC];
    logic [15:0] len  [NC];
    bit          en   [NC];
    bit          flush[NC];
    logic [31:0] mem  [NC][256];
    int          rd   [NC];
    int          wr   [NC];

    // Reference model
    int m_ptr [NC];
    bit m_err [NC];
    int m_last, m_ch, m_left;
    bit m_busy;
    int m_beat;

    // Observations
    int pops [NC];
    int wraps[NC];
    int idle_cnt;
    bit prev_cyc;
    logic [31:0] st_adr[$];
    logic [2:0]  st_cti[$];
    int          st_gap[$];

    int plan_kind, plan_ch, plan_beat;
    bit plan_clr;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int c = 0; c < NC; c++) begin
            ch_enable[c] = en[c];
            ch_flush[c]  = flush[c];
            ch_base[c*AW +: AW] = base[c];
            ch_len[c*LW +: LW]  = len[c];
            ch_level[c*LW +: LW] = LW'(wr[c] - rd[c]);
            ch_data[c*DW +: DW] = mem[c][rd[c] & 255];
        end
    endtask

    task automatic push(input int c, input int n);
        for (int k = 0; k < n; k++) begin
            mem[c][wr[c] & 255] = $urandom;
            wr[c]++;
        end
        drive();
    endtask

    function automatic bit model_req(input int c);
        int lvl;
        lvl = wr[c] - rd[c];
        return en[c] && !m_err[c] && len[c] != 0 &&
               (lvl >= BL || (flush[c] && lvl != 0));
    endfunction

    function automatic int min3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    function automatic logic [63:0] ptr_of(input int c);
        return 64'(ch_wr_ptr[c*LW +: LW]);
    endfunction

    // resp: 0 ack, 1 err, 2 rty, 3 no response this cycle
    task automatic cycle(input int resp);
        int pick, kind, c;
        bit ack, err, rty, was_busy;
        logic [NC-1:0] ev;
        logic [NC-1:0] exp_pop, exp_wrap;
        @(negedge wb_clk);
        for (int i = 0; i < NC; i++) begin
            check("wr_ptr", ptr_of(i), 64'(m_ptr[i]));
            ev[i] = m_err[i];
        end
        check("ch_err", 64'(ch_err), 64'(ev));
        if (wb_cyc_o && !prev_cyc) begin
            st_adr.push_back(wb_adr_o);
            st_cti.push_back(wb_cti_o);
            st_gap.push_back(idle_cnt);
            idle_cnt = 0;
        end
        if (!wb_cyc_o) idle_cnt++;
        prev_cyc = wb_cyc_o;
        pick = -1;
        ack = 0; err = 0; rty = 0;
        if (!m_busy) begin
            check("cyc_idle", 64'(wb_cyc_o), 64'd0);
            check("stb_idle", 64'(wb_stb_o), 64'd0);
            for (int k = 1; k <= NC; k++) begin
                c = (m_last + k) % NC;
                if (pick < 0 && model_req(c)) pick = c;
            end
        end else begin
            check("cyc", 64'(wb_cyc_o), 64'd1);
            check("stb_we_sel", 64'({wb_stb_o, wb_we_o, wb_sel_o, wb_bte_o}),
                  64'({1'b1, 1'b1, 4'hF, 2'b00}));
            check("adr", 64'(wb_adr_o), 64'(base[m_ch] + 32'(4 * m_ptr[m_ch])));
            check("dat", 64'(wb_dat_o), 64'(mem[m_ch][rd[m_ch] & 255]));
            check("cti", 64'(wb_cti_o), (m_left == 1) ? 64'd7 : 64'd2);
            kind = resp;
            if (plan_kind != 0 && m_ch == plan_ch && m_beat == plan_beat) begin
                kind = plan_kind;
                plan_kind = 0;
                if (plan_clr) err_clr[m_ch] = 1'b1;
            end
            ack = (kind == 0);
            err = (kind == 1);
            rty = (kind == 2);
            wb_ack_i = ack; wb_err_i = err; wb_rty_i = rty;
            #1;
            exp_pop = '0;
            exp_wrap = '0;
            if (ack) begin
                exp_pop[m_ch] = 1'b1;
                exp_wrap[m_ch] = (m_ptr[m_ch] == int'(len[m_ch]) - 1);
            end
            check("pop", 64'(ch_pop), 64'(exp_pop));
            check("wrap", 64'(ch_wrap), 64'(exp_wrap));
            for (int i = 0; i < NC; i++) begin
                pops[i] += int'(ch_pop[i]);
                wraps[i] += int'(ch_wrap[i]);
            end
        end
        @(posedge wb_clk);
        #1;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
        was_busy = m_busy;
        for (int i = 0; i < NC; i++) begin
            if (err_clr[i] && !(err && m_ch == i)) m_err[i] = 0;
            if (!en[i] && !(was_busy && m_ch == i)) m_ptr[i] = 0;
        end
        if (was_busy) begin
            if (err) begin
                m_err[m_ch] = 1;
                m_busy = 0;
            end else if (ack) begin
                rd[m_ch]++;
                m_ptr[m_ch] = (m_ptr[m_ch] == int'(len[m_ch]) - 1) ? 0 : m_ptr[m_ch] + 1;
                m_left--;
                m_beat++;
                if (m_left == 0) m_busy = 0;
            end else if (rty) begin
                m_busy = 0;
            end
        end else if (pick >= 0) begin
            m_busy = 1;
            m_ch = pick;
            m_last = pick;
            m_beat = 0;
            m_left = min3(BL, wr[pick] - rd[pick], int'(len[pick]) - m_ptr[pick]);
        end
        err_clr = '0;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle(0);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o, wb_bte_o}), 64'd0);
        check("rst_adr_dat", 64'(wb_adr_o) | 64'(wb_dat_o), 64'd0);
        check("rst_ch", 64'({ch_pop, ch_err, ch_wrap}), 64'd0);
        check("rst_ptr", 64'(ch_wr_ptr), 64'd0);
    endtask

    task automatic setup();
        for (int c = 0; c < NC; c++) begin
            en[c] = 0; flush[c] = 0; len[c] = 0;
            base[c] = 32'h1000 * (c + 1);
            rd[c] = 0; wr[c] = 0;
            pops[c] = 0; wraps[c] = 0;
        end
        st_adr.delete(); st_cti.delete(); st_gap.delete();
        idle_cnt = 0; prev_cyc = 0;
        plan_kind = 0; plan_clr = 0;
        drive();
    endtask

    task automatic do_reset();
        wb_rst = 0;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
        err_clr = '0;
        repeat (2) @(posedge wb_clk);
        #1;
        check_all_zero("reset_outputs");
        for (int c = 0; c < NC; c++) begin
            m_ptr[c] = 0; m_err[c] = 0;
        end
        m_last = NC - 1; m_busy = 0; m_ch = 0; m_left = 0; m_beat = 0;
        wb_rst = 1;
        setup();
    endtask

    task automatic wait_busy(input int max);
        for (int k = 0; k < max && !m_busy; k++) cycle(0);
        if (!m_busy) check("wait_busy", 64'(m_busy), 64'd1);
    endtask

    initial begin
        wb_rst = 0;
        err_clr = '0;
        ch_enable = '0; ch_flush = '0; ch_base = '0; ch_len = '0;
        ch_level = '0; ch_data = '0;
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
        #1;
        setup();
        do_reset();

        // single channel, four beats from base
        en[0] = 1; base[0] = 32'h1000; len[0] = 8;
        push(0, 4);
        run(7);
        check("t1_first_adr", 64'(st_adr[0]), 64'h1000);
        check("t1_latency", 64'(st_gap[0]), 64'd1);
        check("t1_pops", 64'(pops[0]), 64'd4);
        check("t1_ptr", ptr_of(0), 64'd4);

        // all four channels: round-robin with one idle cycle between bursts
        do_reset();
        for (int c = 0; c < NC; c++) begin
            en[c] = 1; len[c] = 64;
            push(c, 8);
        end
        for (int k = 0; k < 60 && st_adr.size() < 8; k++) cycle(0);
        run(6);
        check("t2_bursts", 64'(st_adr.size()), 64'd8);
        for (int k = 0; k < 5 && k < st_adr.size(); k++) begin
            check("t2_order", 64'((st_adr[k] >> 12) - 1), 64'(k % NC));
            check("t2_gap", 64'(st_gap[k]), 64'd1);
        end

        // ring wrap at len 6
        do_reset();
        en[2] = 1; len[2] = 6; base[2] = 32'h2000;
        push(2, 4);
        run(7);
        check("t3_ptr4", ptr_of(2), 64'd4);
        push(2, 4);
        run(6);
        check("t3_wraps", 64'(wraps[2]), 64'd1);
        check("t3_ptr0", ptr_of(2), 64'd0);
        push(2, 2);
        run(7);
        check("t3_bursts", 64'(st_adr.size()), 64'd3);
        if (st_adr.size() >= 3) begin
            check("t3_b2_adr", 64'(st_adr[1]), 64'h2010);
            check("t3_b3_adr", 64'(st_adr[2]), 64'h2000);
        end

        // bus error on beat 2 of channel 1
        do_reset();
        en[0] = 1; len[0] = 64; en[1] = 1; len[1] = 64;
        push(0, 8); push(1, 8);
        plan_kind = 1; plan_ch = 1; plan_beat = 1;
        run(20);
        check("t4_err", 64'(ch_err[1]), 64'd1);
        check("t4_pop1", 64'(pops[1]), 64'd1);
        check("t4_pop0", 64'(pops[0]), 64'd8);
        check("t4_ptr1", ptr_of(1), 64'd1);
        err_clr[1] = 1'b1;
        run(10);
        check("t4_clr", 64'(ch_err[1]), 64'd0);
        check("t4_served", 64'(pops[1]), 64'd5);
        push(1, 4);
        plan_kind = 1; plan_ch = 1; plan_beat = 0; plan_clr = 1;
        run(8);
        check("t4_clr_vs_err", 64'(ch_err[1]), 64'd1);
        check("t4_no_pop", 64'(pops[1]), 64'd5);

        // retry then reset mid-burst
        do_reset();
        en[3] = 1; len[3] = 16;
        push(3, 4);
        run(7);
        plan_kind = 2; plan_ch = 3; plan_beat = 0;
        push(3, 4);
        run(3);
        check("t5_rty_pops", 64'(pops[3]), 64'd4);
        check("t5_rty_ptr", ptr_of(3), 64'd4);
        check("t5_rty_err", 64'(ch_err[3]), 64'd0);
        wait_busy(5);
        #2;
        wb_ack_i = 1;
        wb_rst = 0;
        #1;
        check_all_zero("t5_async_reset");
        @(negedge wb_clk);
        check_all_zero("t5_reset_hold");
        do_reset();

        // flush with a single word; zero-length ring never requests
        en[1] = 1; len[1] = 16; flush[1] = 1;
        en[2] = 1; len[2] = 0;
        push(1, 1); push(2, 8);
        run(6);
        check("t6_pops", 64'(pops[1]), 64'd1);
        check("t6_cti", (st_cti.size() > 0) ? 64'(st_cti[0]) : 64'hX, 64'd7);
        check("t6_len0", 64'(pops[2]), 64'd0);

        // enable dropped mid-burst
        do_reset();
        en[0] = 1; len[0] = 32;
        push(0, 4);
        wait_busy(5);
        en[0] = 0;
        drive();
        run(7);
        check("t7_pops", 64'(pops[0]), 64'd4);
        check("t7_ptr", ptr_of(0), 64'd0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < NC; c++) begin
            en[c] = 1;
            len[c] = 16'($urandom_range(1, 12));
            base[c] = $urandom & 32'hFFFF_FFFC;
            flush[c] = $urandom_range(0, 1) == 1;
        end
        drive();
        for (int k = 0; k < 1500; k++) begin
            int r, c;
            c = $urandom_range(0, NC - 1);
            if ($urandom_range(0, 2) == 0 && wr[c] - rd[c] < 200) push(c, $urandom_range(1, 3));
            if ($urandom_range(0, 39) == 0) begin
                c = $urandom_range(0, NC - 1);
                en[c] = !en[c];
                flush[c] = $urandom_range(0, 1) == 1;
                drive();
            end
            if ($urandom_range(0, 19) == 0) err_clr[$urandom_range(0, NC - 1)] = 1'b1;
            r = $urandom_range(0, 99);
            cycle(r < 70 ? 0 : r < 82 ? 3 : r < 91 ? 2 : 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
